// File: rtl/fec_hv_dac_pkg.sv
// Shared constants and types for the FEC HV bias DAC serial driver.
// Slow-control addresses map chips 0..3 to 0x60..0x63, LDAC strobe at 0x71.
package fec_hv_dac_pkg;

    typedef enum logic [2:0] {
        HV_IDLE  = 3'd0,
        HV_SETUP = 3'd1,
        HV_SHIFT = 3'd2,
        HV_GAP   = 3'd3,
        HV_LDAC  = 3'd4,
        HV_DONE  = 3'd5
    } hv_dac_state_t;

    localparam int          HV_DAC_FRAME_BITS = 24;
    localparam int          HV_DAC_NUM_CHIPS  = 4;
    localparam logic [31:0] HV_DAC_ADDR_BASE  = 32'h60;
    localparam logic [31:0] HV_DAC_ADDR_LDAC  = 32'h71;
    localparam int          HV_DAC_RB_BIT     = 31;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int hv_dac_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int hv_dac_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [31:0] hv_dac_chip_addr(input int chip);
        return HV_DAC_ADDR_BASE + 32'(chip);
    endfunction

endpackage

// File: rtl/fec_hv_dac_sclk_gen.sv
// SCLK divider and bit counter: low phase then high phase per bit, each
// CLK_DIV cycles, with rise/fall/last strobes for the frame sequencer.
module fec_hv_dac_sclk_gen
    import fec_hv_dac_pkg::*;
#(
    parameter int FRAME_BITS = HV_DAC_FRAME_BITS,
    parameter int CLK_DIV    = 4,
    localparam int DIV_W     = hv_dac_cnt_w(CLK_DIV),
    localparam int BIT_W     = hv_dac_cnt_w(FRAME_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    output logic             rise,
    output logic             fall,
    output logic             last,
    output logic [BIT_W-1:0] bit_cnt
);

    logic [DIV_W-1:0] div_cnt;
    logic             high_phase;
    logic             div_end;

    assign div_end = (div_cnt == '0);
    assign rise    = run && div_end && !high_phase;
    assign fall    = run && div_end && high_phase && (bit_cnt != '0);
    assign last    = run && div_end && high_phase && (bit_cnt == '0);

    // start coincides with the first SCLK fall, so the low phase begins next.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            high_phase <= 1'b0;
            bit_cnt    <= '0;
        end else if (start) begin
            div_cnt    <= DIV_W'(CLK_DIV - 1);
            high_phase <= 1'b0;
            bit_cnt    <= BIT_W'(FRAME_BITS - 1);
        end else if (run) begin
            if (div_end) begin
                div_cnt    <= DIV_W'(CLK_DIV - 1);
                high_phase <= !high_phase;
                if (high_phase) begin
                    bit_cnt <= bit_cnt - BIT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/fec_hv_dac_spi.sv
// Serial driver for the FEC HV bias DACs: shifts one frame to the selected
// chips (broadcast allowed) and optionally pulses LOAD_B afterwards.
module fec_hv_dac_spi
    import fec_hv_dac_pkg::*;
#(
    parameter int NUM_DAC    = HV_DAC_NUM_CHIPS,
    parameter int FRAME_BITS = HV_DAC_FRAME_BITS,
    parameter int CLK_DIV    = 4,
    parameter int SETUP_CYC  = 2,
    parameter int GAP_CYC    = 2,
    parameter int LDAC_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // A command transfers on any cycle with cmd_valid && cmd_ready; cmd_ready
    // is a registered IDLE flag, and the requester holds cmd_* until then.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [NUM_DAC-1:0]    cmd_mask,
    input  logic [FRAME_BITS-1:0] cmd_word,
    input  logic                  cmd_ldac,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_DAC-1:0]    hv_dac_sync_b,
    output logic                  hv_dac_sclk,
    output logic                  hv_dac_din,
    output logic                  hv_dac_load_b,
    output logic [2:0]            state_dbg
);

    localparam logic [2:0] ST_IDLE  = HV_IDLE;
    localparam logic [2:0] ST_SETUP = HV_SETUP;
    localparam logic [2:0] ST_SHIFT = HV_SHIFT;
    localparam logic [2:0] ST_GAP   = HV_GAP;
    localparam logic [2:0] ST_LDAC  = HV_LDAC;
    localparam logic [2:0] ST_DONE  = HV_DONE;

    localparam int BIT_W = hv_dac_cnt_w(FRAME_BITS);
    localparam int CNT_W = hv_dac_cnt_w(hv_dac_max3(SETUP_CYC, GAP_CYC, LDAC_CYC));

    logic [2:0]            state;
    logic [CNT_W-1:0]      cyc_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  ldac_q;

    logic                  sg_start;
    logic                  sg_run;
    logic                  sg_rise;
    logic                  sg_fall;
    logic                  sg_last;
    logic [BIT_W-1:0]      sg_bit_cnt;

    assign sg_start  = (state == ST_SETUP) && (cyc_cnt == '0);
    assign sg_run    = (state == ST_SHIFT);
    assign state_dbg = state;

    fec_hv_dac_sclk_gen #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV)
    ) u_sclk_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (sg_start),
        .run     (sg_run),
        .rise    (sg_rise),
        .fall    (sg_fall),
        .last    (sg_last),
        .bit_cnt (sg_bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hv_dac_sync_b <= '1;
            hv_dac_sclk   <= 1'b1;
            hv_dac_din    <= 1'b0;
            hv_dac_load_b <= 1'b1;
            cyc_cnt       <= '0;
            shreg         <= '0;
            ldac_q        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        ldac_q    <= cmd_ldac;
                        shreg     <= {cmd_word[FRAME_BITS-2:0], 1'b0};
                        // An empty mask has nothing to shift; go straight to LOAD_B or completion.
                        if (cmd_mask != '0) begin
                            state         <= ST_SETUP;
                            hv_dac_sync_b <= ~cmd_mask;
                            hv_dac_din    <= cmd_word[FRAME_BITS-1];
                            cyc_cnt       <= CNT_W'(SETUP_CYC - 1);
                        end else if (cmd_ldac) begin
                            state         <= ST_LDAC;
                            hv_dac_load_b <= 1'b0;
                            cyc_cnt       <= CNT_W'(LDAC_CYC - 1);
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cyc_cnt == '0) begin
                        state       <= ST_SHIFT;
                        hv_dac_sclk <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt - CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (sg_rise) begin
                        hv_dac_sclk <= 1'b1;
                        // The DAC has taken this bit on the fall; present the next one.
                        if (sg_bit_cnt != '0) begin
                            hv_dac_din <= shreg[FRAME_BITS-1];
                            shreg      <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end else if (sg_fall) begin
                        hv_dac_sclk <= 1'b0;
                    end else if (sg_last) begin
                        state         <= ST_GAP;
                        hv_dac_sync_b <= '1;
                        hv_dac_din    <= 1'b0;
                        cyc_cnt       <= CNT_W'(GAP_CYC - 1);
                    end
                end
                ST_GAP: begin
                    if (cyc_cnt == '0) begin
                        if (ldac_q) begin
                            state         <= ST_LDAC;
                            hv_dac_load_b <= 1'b0;
                            cyc_cnt       <= CNT_W'(LDAC_CYC - 1);
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt - CNT_W'(1);
                    end
                end
                ST_LDAC: begin
                    if (cyc_cnt == '0) begin
                        state         <= ST_DONE;
                        hv_dac_load_b <= 1'b1;
                        done          <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fec_hv_dac_spi.sv
// Directed bench for fec_hv_dac_spi: default-timing instance plus a fast
// instance (CLK_DIV=1, SETUP_CYC=1, GAP_CYC=1) sharing one command driver.
module tb_fec_hv_dac_spi;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_mask  = '0;
    logic [23:0] cmd_word  = '0;
    logic        cmd_ldac  = 1'b0;
    bit          sel       = 1'b0;

    logic       a_valid, a_ready, a_busy, a_done, a_sclk, a_din, a_load;
    logic [3:0] a_sync;
    logic [2:0] a_state;
    logic       b_valid, b_ready, b_busy, b_done, b_sclk, b_din, b_load;
    logic [3:0] b_sync;
    logic [2:0] b_state;

    assign a_valid = cmd_valid && !sel;
    assign b_valid = cmd_valid && sel;

    fec_hv_dac_spi dut_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_mask(cmd_mask), .cmd_word(cmd_word), .cmd_ldac(cmd_ldac),
        .busy(a_busy), .done(a_done), .hv_dac_sync_b(a_sync), .hv_dac_sclk(a_sclk),
        .hv_dac_din(a_din), .hv_dac_load_b(a_load), .state_dbg(a_state)
    );

    fec_hv_dac_spi #(.CLK_DIV(1), .SETUP_CYC(1), .GAP_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_mask(cmd_mask), .cmd_word(cmd_word), .cmd_ldac(cmd_ldac),
        .busy(b_busy), .done(b_done), .hv_dac_sync_b(b_sync), .hv_dac_sclk(b_sclk),
        .hv_dac_din(b_din), .hv_dac_load_b(b_load), .state_dbg(b_state)
    );

    logic       o_ready, o_busy, o_done, o_sclk, o_din, o_load;
    logic [3:0] o_sync;

    always_comb begin
        o_ready = sel ? b_ready : a_ready;
        o_busy  = sel ? b_busy  : a_busy;
        o_done  = sel ? b_done  : a_done;
        o_sclk  = sel ? b_sclk  : a_sclk;
        o_din   = sel ? b_din   : a_din;
        o_load  = sel ? b_load  : a_load;
        o_sync  = sel ? b_sync  : a_sync;
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // per-command observations, relative to accept cycle T
    logic [3:0]  cur_mask;
    logic [23:0] rx;
    logic        prev_sclk;
    int n_low, first_low, last_low, sync_bad, n_fall, n_tog, stray;
    int n_ld, ld_first, ld_last, done_t, n_done, busy_bad;
    int accept_abs, done_abs, abs_first_low, abs_last_low;
    logic post_ready, post_busy, post_done;

    task automatic clear_stats();
        n_low = 0; first_low = -1; last_low = -1; sync_bad = 0;
        n_fall = 0; n_tog = 0; stray = 0; rx = '0;
        n_ld = 0; ld_first = -1; ld_last = -1;
        done_t = -1; n_done = 0; busy_bad = 0;
        done_abs = 0; abs_first_low = -1; abs_last_low = -1;
        prev_sclk = o_sclk;
    endtask

    task automatic observe(input int t);
        if (o_sync != 4'hF) begin
            if (n_low == 0) begin
                first_low     = t;
                abs_first_low = cyc;
            end
            last_low     = t;
            abs_last_low = cyc;
            n_low++;
            if (o_sync != ~cur_mask) sync_bad++;
        end
        if (o_sclk != prev_sclk) begin
            if (o_sync == 4'hF) stray++;
            else n_tog++;
            if (!o_sclk) begin
                n_fall++;
                rx = {rx[22:0], o_din};
            end
        end
        if (!o_load) begin
            if (n_ld == 0) ld_first = t;
            ld_last = t;
            n_ld++;
        end
        if (!o_busy) busy_bad++;
        if (o_done) begin
            if (n_done == 0) begin
                done_t   = t;
                done_abs = cyc;
            end
            n_done++;
        end
        prev_sclk = o_sclk;
    endtask

    // ---------------- driver ----------------
    // Called at a negedge. With hold set, cmd_valid stays high and the next
    // command is presented right after this one is accepted.
    task automatic run_cmd(input logic [3:0] m, input logic [23:0] w, input logic l,
                           input bit hold, input logic [3:0] nm, input logic [23:0] nw,
                           input logic nl);
        int wt;
        int t;
        cmd_mask  = m;
        cmd_word  = w;
        cmd_ldac  = l;
        cmd_valid = 1'b1;
        cur_mask  = m;
        if (m != 4'h0) exp_q.push_back(w);
        clear_stats();
        wt = 0;
        while (!o_ready && wt < 300) begin
            @(negedge clk);
            wt++;
        end
        check("ready_at_accept", o_ready, 1);
        accept_abs = cyc;
        t = 0;
        while (n_done == 0 && t < 500) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                if (hold) begin
                    cmd_mask = nm;
                    cmd_word = nw;
                    cmd_ldac = nl;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            observe(t);
        end
        @(negedge clk);
        post_ready = o_ready;
        post_busy  = o_busy;
        post_done  = o_done;
        if (m != 4'h0 && exp_q.size() > 0) check("frame_bits", rx, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    int last1, done1, dcount;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sync_b", a_sync, 4'hF);
        check("rst_sclk", a_sclk, 1);
        check("rst_din", a_din, 0);
        check("rst_load_b", a_load, 1);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_ready", a_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", a_ready, 1);

        // single chip, no LDAC
        run_cmd(4'b0001, 24'h000033, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
        check("c1_first_low", first_low, 1);
        check("c1_last_low", last_low, 194);
        check("c1_low_len", n_low, 194);
        check("c1_sync_val", sync_bad, 0);
        check("c1_falls", n_fall, 24);
        check("c1_stray", stray, 0);
        check("c1_no_load", n_ld, 0);
        check("c1_done_t", done_t, 197);
        check("c1_busy", busy_bad, 0);
        check("c1_done_width", post_done, 0);
        check("c1_ready_after", post_ready, 1);
        check("c1_busy_after", post_busy, 0);

        // broadcast to chips 1 and 2, with LDAC
        run_cmd(4'b0110, 24'hF0A5C3, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0);
        check("c2_low_len", n_low, 194);
        check("c2_sync_pair", sync_bad, 0);
        check("c2_falls", n_fall, 24);
        check("c2_ld_first", ld_first, 197);
        check("c2_ld_last", ld_last, 198);
        check("c2_ld_len", n_ld, 2);
        check("c2_done_t", done_t, 199);
        check("c2_busy", busy_bad, 0);

        // empty mask with LDAC
        run_cmd(4'b0000, 24'hFFFFFF, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0);
        check("c3_no_sync", n_low, 0);
        check("c3_no_sclk", n_tog + stray, 0);
        check("c3_ld_first", ld_first, 1);
        check("c3_ld_last", ld_last, 2);
        check("c3_done_t", done_t, 3);

        // empty mask, no LDAC
        run_cmd(4'b0000, 24'h123456, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
        check("c4_done_t", done_t, 1);
        check("c4_no_activity", n_low + n_ld + stray, 0);
        check("c4_ready_after", post_ready, 1);

        // back-to-back with cmd_valid held
        run_cmd(4'b0001, 24'h123456, 1'b0, 1'b1, 4'b0010, 24'hABCDEF, 1'b0);
        last1 = abs_last_low;
        done1 = done_abs;
        run_cmd(4'b0010, 24'hABCDEF, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
        check("b2b_accept", accept_abs - done1, 1);
        check("b2b_gap", abs_first_low - last1 - 1, 4);
        check("b2b_done_t", done_t, 197);

        // reset at the 10th SCLK fall
        cmd_mask = 4'b0100; cmd_word = 24'h5A5A5A; cmd_ldac = 1'b1; cmd_valid = 1'b1;
        cur_mask = 4'b0100;
        clear_stats();
        dcount = 0;
        while (!o_ready && dcount < 300) begin
            @(negedge clk);
            dcount++;
        end
        dcount = 0;
        while (n_fall < 10 && dcount < 500) begin
            @(negedge clk);
            dcount++;
            if (dcount == 1) cmd_valid = 1'b0;
            observe(dcount);
        end
        check("abort_reach_fall10", n_fall, 10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sync_b", a_sync, 4'hF);
        check("abort_sclk", a_sclk, 1);
        check("abort_din", a_din, 0);
        check("abort_load_b", a_load, 1);
        check("abort_busy", a_busy, 0);
        check("abort_ready", a_ready, 0);
        dcount = int'(a_done);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", a_ready, 1);
        dcount += int'(a_done);
        repeat (4) begin
            @(negedge clk);
            dcount += int'(a_done);
        end
        check("abort_no_done", dcount, 0);
        run_cmd(4'b0100, 24'h5A5A5A, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0);
        check("abort_next_done_t", done_t, 199);
        check("abort_next_low_len", n_low, 194);

        // fast timing instance
        sel = 1'b1;
        @(negedge clk);
        run_cmd(4'b1000, 24'h00C0DE, 1'b0, 1'b0, 4'h0, 24'h0, 1'b0);
        check("fast_first_low", first_low, 1);
        check("fast_low_len", n_low, 49);
        check("fast_toggles", n_tog, 48);
        check("fast_falls", n_fall, 24);
        check("fast_stray", stray, 0);
        check("fast_done_t", done_t, 51);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
